// File: rtl/lfclk_axil_regs.sv
// AXI4-Lite register slave for the low-frequency clock generator: four RW registers
// (CTRL, DIV, NPULSE, SCRATCH) and a divided clock with optional pulse-count stop.
module lfclk_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            lf_clk,
  output logic                            lf_done
);

  localparam int NREG  = 4;
  localparam int NBYTE = C_S_AXI_DATA_WIDTH / 8;

  typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} gen_state_e;

  word_t            regs [NREG];
  logic             ready_en;
  logic             aw_latched, w_latched;
  logic [1:0]       aw_idx_q;
  word_t            w_data_q;
  logic [NBYTE-1:0] w_strb_q;
  logic             bvalid, rvalid;
  word_t            rdata;

  logic             aw_hs, w_hs, ar_hs, commit;
  logic [1:0]       wr_idx;
  word_t            wr_data;
  logic [NBYTE-1:0] wr_strb;

  // Readies are held low until the first clock after reset so every handshake output is 0 in reset.
  assign S_AXI_AWREADY = ready_en & ~aw_latched & ~bvalid;
  assign S_AXI_WREADY  = ready_en & ~w_latched  & ~bvalid;
  assign S_AXI_ARREADY = ready_en & ~rvalid;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = (aw_latched | aw_hs) & (w_latched | w_hs);

  assign wr_idx  = aw_latched ? aw_idx_q : S_AXI_AWADDR[3:2];
  assign wr_data = w_latched  ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_latched  ? w_strb_q : S_AXI_WSTRB;

  assign S_AXI_BRESP  = 2'b00;
  assign S_AXI_RRESP  = 2'b00;
  assign S_AXI_BVALID = bvalid;
  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RDATA  = rdata;

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_latched <= 1'b0;
      aw_idx_q   <= '0;
      w_latched  <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid     <= 1'b0;
    end else begin
      if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
      if (commit) begin
        aw_latched <= 1'b0;
        w_latched  <= 1'b0;
        bvalid     <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_latched <= 1'b1;
          aw_idx_q   <= S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_latched <= 1'b1;
          w_data_q  <= S_AXI_WDATA;
          w_strb_q  <= S_AXI_WSTRB;
        end
      end
    end
  end

  // NOTE: the register file is software-visible and must read 0 after reset, so it is reset like any flop.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < NBYTE; b++)
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // A read accepted in the same cycle as a write commit samples the pre-write register value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= regs[S_AXI_ARADDR[3:2]];
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  gen_state_e           state, state_next;
  logic [CNT_WIDTH-1:0] div_cnt, div_cnt_d, pulse_cnt, pulse_cnt_d;
  logic [CNT_WIDTH-1:0] div_val, npulse_val;
  logic                 phase, phase_d, tick, last_pulse, en, inv;

  assign en         = regs[0][0];
  assign inv        = regs[0][1];
  assign div_val    = regs[1][CNT_WIDTH-1:0];
  assign npulse_val = regs[2][CNT_WIDTH-1:0];
  assign tick       = (div_cnt == div_val);
  assign last_pulse = (npulse_val != '0) && (pulse_cnt >= npulse_val);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = IDLE;
               else if (tick && phase && last_pulse) state_next = DONE;
      DONE:    if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    div_cnt_d   = '0;
    pulse_cnt_d = '0;
    phase_d     = 1'b0;
    lf_done     = (state == DONE);
    // Counters and phase only advance while staying in RUN; any exit clears them.
    if (state == RUN && state_next == RUN) begin
      div_cnt_d   = tick ? '0 : div_cnt + 1'b1;
      phase_d     = tick ? ~phase : phase;
      pulse_cnt_d = (tick && !phase && pulse_cnt != '1) ? pulse_cnt + 1'b1 : pulse_cnt;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      div_cnt   <= '0;
      pulse_cnt <= '0;
      phase     <= 1'b0;
      lf_clk    <= 1'b0;
    end else begin
      div_cnt   <= div_cnt_d;
      pulse_cnt <= pulse_cnt_d;
      phase     <= phase_d;
      lf_clk    <= phase ^ inv;
    end
  end

endmodule

// File: tb/tb_lfclk_axil_regs.sv
// Directed bench for lfclk_axil_regs: AXI-Lite register access, write ordering,
// byte strobes, clock divider timing, pulse-count stop and asynchronous reset.
module tb_lfclk_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        lf_clk;
  logic        lf_done;

  int checks = 0;
  int errors = 0;

  lfclk_axil_regs dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .lf_clk(lf_clk), .lf_done(lf_done)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; AW and W are raised at cycle offsets aw_start / w_start.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_start, input int w_start, input int bready_delay);
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = !aw_done && cyc >= aw_start;
      S_AXI_WVALID  = !w_done && cyc >= w_start;
      #1;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK);
      if (aw_hs) aw_done = 1'b1;
      if (w_hs)  w_done  = 1'b1;
      @(negedge ACLK);
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("wr_accept", 32'(aw_done && w_done), 1);
    if (aw_start == 0 && w_start == 0) check("wr_min_latency", 32'(S_AXI_BVALID), 1);
    cyc = 0;
    while (!S_AXI_BVALID && cyc < 20) begin
      @(negedge ACLK);
      cyc++;
    end
    check("bvalid", 32'(S_AXI_BVALID), 1);
    check("bresp", 32'(S_AXI_BRESP), 0);
    for (int i = 0; i < bready_delay; i++) begin
      @(negedge ACLK);
      check("bvalid_hold", 32'(S_AXI_BVALID), 1);
      check("no_awready", 32'(S_AXI_AWREADY), 0);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("bvalid_clear", 32'(S_AXI_BVALID), 0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int rready_delay, output logic [31:0] data);
    bit hs = 1'b0;
    int n = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!hs && n < 20) begin
      #1;
      hs = S_AXI_ARREADY;
      @(posedge ACLK);
      @(negedge ACLK);
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("rvalid", 32'(S_AXI_RVALID), 1);
    check("rresp", 32'(S_AXI_RRESP), 0);
    data = S_AXI_RDATA;
    for (int i = 0; i < rready_delay; i++) begin
      @(negedge ACLK);
      check("rdata_hold", S_AXI_RDATA, data);
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    check("rvalid_clear", 32'(S_AXI_RVALID), 0);
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, 0, d);
    check(tag, d, exp);
  endtask

  // Finds the next rising lf_clk and measures one high and one low run in ACLK cycles.
  task automatic measure(output int hi, output int lo);
    int n = 0;
    while (lf_clk !== 1'b0 && n < 100) begin @(negedge ACLK); n++; end
    while (lf_clk !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
    hi = 0;
    while (lf_clk === 1'b1 && hi < 100) begin @(negedge ACLK); hi++; end
    lo = 0;
    while (lf_clk === 1'b0 && lo < 100) begin @(negedge ACLK); lo++; end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                S_AXI_RVALID, lf_clk, lf_done}, 0);
    check(tag, S_AXI_RDATA, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hi, lo, pulses, run;
    logic prev;
    logic [31:0] d;

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA  = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    check_all_zero("reset_outputs");
    ARESET = 1'b0;
    @(negedge ACLK);
    check("awready_after_reset", 32'(S_AXI_AWREADY), 1);

    // Basic write/readback of all four registers
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'd2, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'd3, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'd4, 4'hF, 0, 0, 0);
    read_check("rd_ctrl", 4'h0, 32'd1);
    read_check("rd_div", 4'h4, 32'd2);
    read_check("rd_npulse", 4'h8, 32'd3);
    axi_read(4'hC, 3, d);
    check("rd_scratch", d, 32'd4);

    // AW before W (held BREADY), then W before AW
    axi_write(4'hC, 32'h0F0F_F0F0, 4'hF, 0, 3, 5);
    read_check("rd_aw_first", 4'hC, 32'h0F0F_F0F0);
    axi_write(4'hC, 32'hA5A5_5A5A, 4'hF, 3, 0, 0);
    read_check("rd_w_first", 4'hC, 32'hA5A5_5A5A);

    // Byte strobes
    axi_write(4'hC, 32'h0, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'h1234_5678, 4'b0010, 0, 0, 0);
    read_check("rd_strobe", 4'hC, 32'h0000_5600);

    // Read and write commit to SCRATCH in the same cycle: read sees old value
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 4'hC;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("same_cycle_rdata", S_AXI_RDATA, 32'h0000_5600);
    check("same_cycle_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd3);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    read_check("rd_after_same_cycle", 4'hC, 32'hDEAD_BEEF);

    // Free-running divider: DIV=4 -> 5 high / 5 low, then inverted
    axi_write(4'h0, 32'd0, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'd4, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'd0, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
    measure(hi, lo);
    check("div4_high", hi, 5);
    check("div4_low", lo, 5);
    check("div4_not_done", 32'(lf_done), 0);
    axi_write(4'h0, 32'd2, 4'hF, 0, 0, 0);
    repeat (2) @(negedge ACLK);
    check("idle_inverted", 32'(lf_clk), 1);
    axi_write(4'h0, 32'd3, 4'hF, 0, 0, 0);
    measure(hi, lo);
    check("inv_high", hi, 5);
    check("inv_low", lo, 5);

    // DIV=0 -> ACLK/2
    axi_write(4'h0, 32'd0, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'd0, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
    measure(hi, lo);
    check("div0_high", hi, 1);
    check("div0_low", lo, 1);

    // Pulse-count stop: DIV=1, NPULSE=3
    axi_write(4'h0, 32'd0, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'd1, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'd3, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
    pulses = 0; run = 0; prev = lf_clk;
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      if (!prev && lf_clk) pulses++;
      if (lf_clk) run++;
      if (prev && !lf_clk) begin
        check("npulse_width", run, 2);
        run = 0;
      end
      prev = lf_clk;
    end
    check("npulse_count", pulses, 3);
    check("npulse_clk_low", 32'(lf_clk), 0);
    check("npulse_done", 32'(lf_done), 1);
    axi_write(4'h0, 32'd0, 4'hF, 0, 0, 0);
    check("done_cleared", 32'(lf_done), 0);

    // Asynchronous reset with write response, read data and generator pending
    axi_write(4'h4, 32'd2, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'd0, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'd7; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 4'h0;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    repeat (2) @(negedge ACLK);
    check("pre_reset_pending", {29'd0, S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA[0]}, 32'd7);
    #2 ARESET = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    read_check("rst_ctrl", 4'h0, 32'd0);
    read_check("rst_div", 4'h4, 32'd0);
    read_check("rst_npulse", 4'h8, 32'd0);
    read_check("rst_scratch", 4'hC, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
